// File: rtl/mips_decode_ctrl.sv
// -----------------------------------------------------------------------------
// mips_decode_ctrl
//   Multi-cycle decode/control stage sitting in front of the datapath `dp`.
//   Accepts one 32-bit MIPS instruction per valid/ready handshake, decodes the
//   R-type (AND/OR/ADD/SUB/SLT/NOR) and I-type (ANDI/ORI/ADDI/SLTI) ALU subset,
//   drives the datapath for EXEC_CYCLES cycles, then samples the datapath flags
//   to gate the register write-back.
//
// Parameters
//   EXEC_CYCLES  cycles the datapath inputs are held before flags are sampled
//                (legal range 1..15)
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   instr             instruction word, qualified by instr_valid
//   instr_valid       upstream has an instruction
//   instr_ready       stage can accept an instruction (high only in IDLE)
//   read1, read2      rs / rt register addresses to the datapath
//   write_reg         destination register to the datapath
//   alu_op            4-bit ALU control to the datapath
//   inm               16-bit immediate to the datapath
//   sel               operand select: 0 = register B, 1 = immediate
//   zero, overflow    datapath flags, sampled at the end of the last EXEC cycle
//   reg_write         one-cycle write-enable pulse in WB
//   done              one-cycle pulse when an instruction retires or traps
//   ovf_exc           one-cycle pulse: signed overflow, write suppressed
//   illegal           one-cycle pulse: unsupported encoding, no write
//
// Optional feature (macro DECODE_CTRL_PERF_CNT_EN)
//   retired_cnt, trap_cnt, busy_cycles: 32-bit wrapping performance counters.
// -----------------------------------------------------------------------------
module mips_decode_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [4:0]  read1,
  output logic [4:0]  read2,
  output logic [4:0]  write_reg,
  output logic [3:0]  alu_op,
  output logic [15:0] inm,
  output logic        sel,
  input  logic        zero,
  input  logic        overflow,
  output logic        reg_write,
  output logic        done,
  output logic        ovf_exc,
  output logic        illegal
`ifdef DECODE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] trap_cnt,
  output logic [31:0] busy_cycles
`endif
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  // Result of decoding the incoming instruction word.
  typedef struct packed {
    logic              legal;
    logic              arith;      // ADD/SUB/ADDI: overflow traps
    logic              sel;
    logic [REG_W-1:0]  write_reg;
    logic [OP_W-1:0]   alu_op;
  } dec_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic               arith_q, arith_d;

  logic               instr_ready_d;
  logic [REG_W-1:0]   read1_d, read2_d, write_reg_d;
  logic [OP_W-1:0]    alu_op_d;
  logic [IMM_W-1:0]   inm_d;
  logic               sel_d;
  logic               reg_write_d, done_d, ovf_exc_d, illegal_d;

  dec_t               dec_c;

  // The zero flag is forwarded by the datapath but never changes the outcome.
  logic               unused_zero;
  assign unused_zero = zero;

  // Instruction decode straight from the input word; used at the handshake.
  always_comb begin
    dec_c = '0;
    unique case (instr[31:26])
      OPC_RTYPE: begin
        dec_c.legal     = 1'b1;
        dec_c.sel       = 1'b0;
        dec_c.write_reg = instr[15:11];
        unique case (instr[5:0])
          FN_AND:  dec_c.alu_op = ALU_AND;
          FN_OR:   dec_c.alu_op = ALU_OR;
          FN_NOR:  dec_c.alu_op = ALU_NOR;
          FN_SLT:  dec_c.alu_op = ALU_SLT;
          FN_ADD: begin
            dec_c.alu_op = ALU_ADD;
            dec_c.arith  = 1'b1;
          end
          FN_SUB: begin
            dec_c.alu_op = ALU_SUB;
            dec_c.arith  = 1'b1;
          end
          default: dec_c.legal = 1'b0;
        endcase
      end
      OPC_ANDI, OPC_ORI, OPC_ADDI, OPC_SLTI: begin
        dec_c.legal     = 1'b1;
        dec_c.sel       = 1'b1;
        dec_c.write_reg = instr[20:16];
        unique case (instr[31:26])
          OPC_ANDI: dec_c.alu_op = ALU_AND;
          OPC_ORI:  dec_c.alu_op = ALU_OR;
          OPC_ADDI: begin
            dec_c.alu_op = ALU_ADD;
            dec_c.arith  = 1'b1;
          end
          default:  dec_c.alu_op = ALU_SLT;
        endcase
      end
      default: dec_c = '0;
    endcase
  end

  // Next-state and next-output logic; datapath outputs hold unless reloaded.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bad_d         = bad_q;
    arith_d       = arith_q;
    instr_ready_d = instr_ready;
    read1_d       = read1;
    read2_d       = read2;
    write_reg_d   = write_reg;
    alu_op_d      = alu_op;
    inm_d         = inm;
    sel_d         = sel;
    reg_write_d   = 1'b0;
    done_d        = 1'b0;
    ovf_exc_d     = 1'b0;
    illegal_d     = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready_d = 1'b1;
        if (instr_valid && instr_ready) begin
          state_d       = DECODE;
          instr_ready_d = 1'b0;
          read1_d       = instr[25:21];
          read2_d       = instr[20:16];
          inm_d         = instr[15:0];
          write_reg_d   = dec_c.write_reg;
          alu_op_d      = dec_c.alu_op;
          sel_d         = dec_c.sel;
          bad_d         = ~dec_c.legal;
          arith_d       = dec_c.arith;
        end
      end
      DECODE: begin
        if (bad_q) begin
          // Unsupported encodings skip EXEC and trap directly in WB.
          state_d   = WB;
          illegal_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          state_d = EXEC;
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          // Last EXEC edge: the flags seen here decide the WB outcome.
          state_d = WB;
          done_d  = 1'b1;
          if (arith_q && overflow) begin
            ovf_exc_d = 1'b1;
          end else begin
            reg_write_d = (write_reg != '0);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        state_d       = IDLE;
        instr_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      arith_q     <= 1'b0;
      instr_ready <= 1'b1;
      read1       <= '0;
      read2       <= '0;
      write_reg   <= '0;
      alu_op      <= '0;
      inm         <= '0;
      sel         <= 1'b0;
      reg_write   <= 1'b0;
      done        <= 1'b0;
      ovf_exc     <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      arith_q     <= arith_d;
      instr_ready <= instr_ready_d;
      read1       <= read1_d;
      read2       <= read2_d;
      write_reg   <= write_reg_d;
      alu_op      <= alu_op_d;
      inm         <= inm_d;
      sel         <= sel_d;
      reg_write   <= reg_write_d;
      done        <= done_d;
      ovf_exc     <= ovf_exc_d;
      illegal     <= illegal_d;
    end
  end

`ifdef DECODE_CTRL_PERF_CNT_EN
  // Performance counters, all wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      trap_cnt    <= '0;
      busy_cycles <= '0;
    end else begin
      if (state_q != IDLE) begin
        busy_cycles <= busy_cycles + 32'd1;
      end
      if ((state_q == WB) && (reg_write || (done && !illegal && !ovf_exc))) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if ((state_q == WB) && (illegal || ovf_exc)) begin
        trap_cnt <= trap_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_decode_ctrl.sv
`timescale 1ns/1ps
// Testbench for mips_decode_ctrl: two instances (EXEC_CYCLES = 1 and 4) driven
// with directed and randomized instructions, checked against a table-driven
// reference model of the decode rules and the cycle timing.
module tb_mips_decode_ctrl;

  localparam int unsigned NDUT   = 2;
  localparam int unsigned EXEC_A = 1;
  localparam int unsigned EXEC_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr       [NDUT];
  logic        instr_valid [NDUT];
  logic        instr_ready [NDUT];
  logic [4:0]  read1       [NDUT];
  logic [4:0]  read2       [NDUT];
  logic [4:0]  write_reg   [NDUT];
  logic [3:0]  alu_op      [NDUT];
  logic [15:0] inm         [NDUT];
  logic        sel         [NDUT];
  logic        zero        [NDUT];
  logic        overflow    [NDUT];
  logic        reg_write   [NDUT];
  logic        done        [NDUT];
  logic        ovf_exc     [NDUT];
  logic        illegal     [NDUT];
`ifdef DECODE_CTRL_PERF_CNT_EN
  logic [31:0] retired_cnt [NDUT];
  logic [31:0] trap_cnt    [NDUT];
  logic [31:0] busy_cycles [NDUT];
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference tables: funct -> ALU op (R-type), opcode -> ALU op (I-type).
  logic [3:0] r_alu [int];
  logic [3:0] i_alu [int];

  always #5 clk = ~clk;

  mips_decode_ctrl #(.EXEC_CYCLES(EXEC_A)) dut_a (
    .clk(clk), .rst(rst), .instr(instr[0]), .instr_valid(instr_valid[0]),
    .instr_ready(instr_ready[0]), .read1(read1[0]), .read2(read2[0]),
    .write_reg(write_reg[0]), .alu_op(alu_op[0]), .inm(inm[0]), .sel(sel[0]),
    .zero(zero[0]), .overflow(overflow[0]), .reg_write(reg_write[0]),
    .done(done[0]), .ovf_exc(ovf_exc[0]), .illegal(illegal[0])
`ifdef DECODE_CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt[0]), .trap_cnt(trap_cnt[0]), .busy_cycles(busy_cycles[0])
`endif
  );

  mips_decode_ctrl #(.EXEC_CYCLES(EXEC_B)) dut_b (
    .clk(clk), .rst(rst), .instr(instr[1]), .instr_valid(instr_valid[1]),
    .instr_ready(instr_ready[1]), .read1(read1[1]), .read2(read2[1]),
    .write_reg(write_reg[1]), .alu_op(alu_op[1]), .inm(inm[1]), .sel(sel[1]),
    .zero(zero[1]), .overflow(overflow[1]), .reg_write(reg_write[1]),
    .done(done[1]), .ovf_exc(ovf_exc[1]), .illegal(illegal[1])
`ifdef DECODE_CTRL_PERF_CNT_EN
    , .retired_cnt(retired_cnt[1]), .trap_cnt(trap_cnt[1]), .busy_cycles(busy_cycles[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exec_of(input int d);
    return (d == 0) ? EXEC_A : EXEC_B;
  endfunction

  // Decode rules from the instruction-set tables; ADD and SUB ops can trap.
  function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                     output logic [3:0] op, output bit sel_e,
                                     output logic [4:0] wr, output bit arith);
    int opc;
    int fn;
    opc   = int'(w[31:26]);
    fn    = int'(w[5:0]);
    legal = 1'b0; op = 4'd0; sel_e = 1'b0; wr = 5'd0; arith = 1'b0;
    if (opc == 0 && r_alu.exists(fn)) begin
      legal = 1'b1; op = r_alu[fn]; wr = w[15:11];
    end else if (opc != 0 && i_alu.exists(opc)) begin
      legal = 1'b1; op = i_alu[opc]; sel_e = 1'b1; wr = w[20:16];
    end
    arith = legal && (op == 4'b0010 || op == 4'b0110);
  endfunction

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_ready"},     32'(instr_ready[d]), 32'd1);
    chk({tag, "_read1"},     32'(read1[d]),       32'd0);
    chk({tag, "_read2"},     32'(read2[d]),       32'd0);
    chk({tag, "_write_reg"}, 32'(write_reg[d]),   32'd0);
    chk({tag, "_alu_op"},    32'(alu_op[d]),      32'd0);
    chk({tag, "_inm"},       32'(inm[d]),         32'd0);
    chk({tag, "_sel"},       32'(sel[d]),         32'd0);
    chk({tag, "_reg_write"}, 32'(reg_write[d]),   32'd0);
    chk({tag, "_done"},      32'(done[d]),        32'd0);
    chk({tag, "_ovf_exc"},   32'(ovf_exc[d]),     32'd0);
    chk({tag, "_illegal"},   32'(illegal[d]),     32'd0);
  endtask

  // Issue one instruction at a negedge in IDLE and check every cycle up to the
  // cycle after WB. ovf_final is the overflow flag at the last EXEC edge; all
  // other cycles see random flag glitches and random instr_valid/instr noise.
  task automatic run_instr(input int d, input logic [31:0] w, input bit ovf_final, input bit hold);
    bit         legal, sel_e, arith, exp_rw, exp_ovf;
    logic [3:0] op;
    logic [4:0] wr;
    int         wb;
    ref_decode(w, legal, op, sel_e, wr, arith);
    wb      = legal ? 2 + int'(exec_of(d)) : 2;
    exp_ovf = legal && arith && ovf_final;
    exp_rw  = legal && !exp_ovf && (wr != 5'd0);
    instr[d]       = w;
    instr_valid[d] = 1'b1;
    chk("idle_ready", 32'(instr_ready[d]), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= wb; k++) begin
      @(negedge clk);
      chk("busy_ready", 32'(instr_ready[d]), 32'd0);
      chk("read1", 32'(read1[d]), 32'(w[25:21]));
      chk("read2", 32'(read2[d]), 32'(w[20:16]));
      chk("inm",   32'(inm[d]),   32'(w[15:0]));
      if (legal) begin
        chk("alu_op",    32'(alu_op[d]),    32'(op));
        chk("sel",       32'(sel[d]),       32'(sel_e));
        chk("write_reg", 32'(write_reg[d]), 32'(wr));
      end
      chk("done",      32'(done[d]),      32'(k == wb));
      chk("reg_write", 32'(reg_write[d]), 32'((k == wb) && exp_rw));
      chk("ovf_exc",   32'(ovf_exc[d]),   32'((k == wb) && exp_ovf));
      chk("illegal",   32'(illegal[d]),   32'((k == wb) && !legal));
      instr[d]       = $urandom;
      instr_valid[d] = hold ? 1'b1 : 1'($urandom_range(0, 1));
      overflow[d]    = (legal && k == wb - 1) ? ovf_final : 1'($urandom_range(0, 1));
      zero[d]        = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("post_ready",     32'(instr_ready[d]), 32'd1);
    chk("post_done",      32'(done[d]),        32'd0);
    chk("post_reg_write", 32'(reg_write[d]),   32'd0);
    chk("post_ovf_exc",   32'(ovf_exc[d]),     32'd0);
    chk("post_illegal",   32'(illegal[d]),     32'd0);
    chk("post_read1",     32'(read1[d]),       32'(w[25:21]));
    chk("post_inm",       32'(inm[d]),         32'(w[15:0]));
    instr_valid[d] = hold;
  endtask

  // Start an instruction and assert rst during cycle at_k after the handshake.
  task automatic run_abort(input int d, input logic [31:0] w, input int at_k);
    instr[d]       = w;
    instr_valid[d] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= at_k; k++) begin
      @(negedge clk);
      instr_valid[d] = 1'b0;
      overflow[d]    = 1'($urandom_range(0, 1));
    end
    chk("abort_pre_ready", 32'(instr_ready[d]), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset(d, "abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_done",      32'(done[d]),        32'd0);
      chk("abort_no_reg_write", 32'(reg_write[d]),   32'd0);
      chk("abort_idle_ready",   32'(instr_ready[d]), 32'd1);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns  [6];
    logic [5:0] opcs [4];
    fns  = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27};
    opcs = '{6'h0C, 6'h0D, 6'h08, 6'h0A};
    r_alu[32'h24] = 4'b0000; r_alu[32'h25] = 4'b0001; r_alu[32'h20] = 4'b0010;
    r_alu[32'h22] = 4'b0110; r_alu[32'h2A] = 4'b0111; r_alu[32'h27] = 4'b1100;
    i_alu[32'h0C] = 4'b0000; i_alu[32'h0D] = 4'b0001; i_alu[32'h08] = 4'b0010;
    i_alu[32'h0A] = 4'b0111;

    rst = 1'b1;
    for (int d = 0; d < int'(NDUT); d++) begin
      instr[d] = '0; instr_valid[d] = 1'b0; zero[d] = 1'b0; overflow[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0, "rst_a");
    chk_reset(1, "rst_b");
    rst = 1'b0;
    @(negedge clk);
    chk_reset(0, "idle_a");

    // Directed cases.
    run_instr(0, 32'h00221820, 1'b0, 1'b0);   // ADD rs=1 rt=2 rd=3
    run_instr(0, 32'h3422FFFF, 1'b0, 1'b0);   // ORI rs=1 rt=2 imm=FFFF
    run_instr(0, 32'h00221820, 1'b1, 1'b0);   // ADD overflow trap
    run_instr(0, 32'h00221824, 1'b1, 1'b0);   // AND ignores overflow
    run_instr(0, 32'hFC221820, 1'b0, 1'b0);   // opcode 0x3F illegal
    run_instr(0, 32'h0022002A, 1'b0, 1'b0);   // SLT rd=0, no write
    run_instr(0, 32'h00A41822, 1'b1, 1'b0);   // SUB overflow trap
    run_instr(1, 32'h2085FFFF, 1'b1, 1'b0);   // ADDI overflow trap
    run_instr(1, 32'h28E68000, 1'b1, 1'b0);   // SLTI ignores overflow
    run_instr(1, 32'h3000ABCD, 1'b0, 1'b0);   // ANDI rt=0, no write
    run_instr(1, 32'h00221831, 1'b0, 1'b0);   // R-type funct 0x31 illegal

    // Back-to-back NOR with instr_valid held high.
    for (int i = 0; i < 4; i++) begin
      run_instr(1, rtype(6'h27, 5'($urandom), 5'($urandom), 5'(i + 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    instr_valid[1] = 1'b0;

    // Reset in the middle of EXEC, then normal operation resumes.
    run_abort(1, 32'h00221820, 3);
    run_instr(1, 32'h00221820, 1'b0, 1'b0);
    run_abort(0, 32'h00221820, 2);
    run_instr(0, 32'h3422FFFF, 1'b0, 1'b0);

    // Randomized instructions over both instances.
    for (int i = 0; i < 80; i++) begin
      int          d;
      int          kind;
      logic [31:0] w;
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      case (kind)
        0, 1:    w = rtype(fns[$urandom_range(0, 5)], 5'($urandom), 5'($urandom), 5'($urandom));
        2:       w = itype(opcs[$urandom_range(0, 3)], 5'($urandom), 5'($urandom), 16'($urandom));
        default: w = $urandom;
      endcase
      run_instr(d, w, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
